uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Valid/ready byte stream carrying received characters out of uart_rx.
interface taxi_axis_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 5..8 data bits, optional parity, one stop bit, 8x oversampled baud pulse.
// Define UART_RX_MAJORITY_EN to vote each bit from three samples instead of one.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic        baud_clk,
    input  logic        rxd,
    taxi_axis_if.master m_axis,
    input  logic [1:0]  data_bits,
    input  logic        parity_en,
    input  logic        parity_type,
    output logic        busy,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxdPrev_q;
    logic [2:0]             baudCnt_q;
    logic [2:0]             bitCnt_q;
    logic [1:0]             dataBits_q;
    logic                   parityEn_q;
    logic                   parityType_q;
    logic [7:0]             shift_q;
    logic                   parityAcc_q;
    logic                   parityBad_q;
    logic                   tvalid_q;
    logic [7:0]             tdata_q;
    logic                   frameErr_q;
    logic                   parityErr_q;
    logic                   overrunErr_q;

    logic       rxdSync_d;
    logic       bitVal_d;
    logic       tick_d;
    logic       lastBit_d;
    logic [7:0] byte_d;

    assign rxdSync_d = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the third sample, so the decision lands on pulse 5 of each window.
    localparam logic [2:0] FIRST_TICK = 3'd4;
    logic [1:0] hist_q;
    assign bitVal_d = (hist_q[0] & hist_q[1]) | (hist_q[0] & rxdSync_d) | (hist_q[1] & rxdSync_d);
`else
    localparam logic [2:0] FIRST_TICK = 3'd3;
    assign bitVal_d = rxdSync_d;
`endif

    assign tick_d    = baud_clk && (baudCnt_q == ((state_q == START) ? FIRST_TICK : 3'd7));
    assign lastBit_d = (bitCnt_q == (3'd7 - {1'b0, dataBits_q}));
    // Bits enter at the MSB, so short characters sit high and are shifted down here.
    assign byte_d    = shift_q >> dataBits_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            rxdPrev_q    <= 1'b1;
            baudCnt_q    <= '0;
            bitCnt_q     <= '0;
            dataBits_q   <= '0;
            parityEn_q   <= 1'b0;
            parityType_q <= 1'b0;
            shift_q      <= '0;
            parityAcc_q  <= 1'b0;
            parityBad_q  <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            frameErr_q   <= 1'b0;
            parityErr_q  <= 1'b0;
            overrunErr_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxdPrev_q    <= rxdSync_d;
            frameErr_q   <= 1'b0;
            parityErr_q  <= 1'b0;
            overrunErr_q <= 1'b0;
            if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
            end
            if (!En) begin
                state_q   <= IDLE;
                baudCnt_q <= '0;
                bitCnt_q  <= '0;
            end else if (state_q == IDLE) begin
                if (rxdPrev_q && !rxdSync_d) begin
                    state_q      <= START;
                    baudCnt_q    <= '0;
                    bitCnt_q     <= '0;
                    dataBits_q   <= data_bits;
                    parityEn_q   <= parity_en;
                    parityType_q <= parity_type;
                    shift_q      <= '0;
                    parityAcc_q  <= 1'b0;
                    parityBad_q  <= 1'b0;
                end
            end else if (baud_clk) begin
                baudCnt_q <= tick_d ? 3'd0 : baudCnt_q + 3'd1;
                if (tick_d) begin
                    case (state_q)
                        START: state_q <= bitVal_d ? IDLE : DATA;
                        DATA: begin
                            shift_q     <= {bitVal_d, shift_q[7:1]};
                            parityAcc_q <= parityAcc_q ^ bitVal_d;
                            bitCnt_q    <= bitCnt_q + 3'd1;
                            if (lastBit_d) begin
                                state_q <= parityEn_q ? PARITY : STOP;
                            end
                        end
                        PARITY: begin
                            parityBad_q <= bitVal_d != (parityAcc_q ^ parityType_q);
                            state_q     <= STOP;
                        end
                        STOP: begin
                            state_q     <= IDLE;
                            frameErr_q  <= !bitVal_d;
                            parityErr_q <= parityBad_q;
                            // A same-cycle acceptance frees the holding register for the new byte.
                            if (bitVal_d && !parityBad_q) begin
                                if (!tvalid_q || m_axis.tready) begin
                                    tvalid_q <= 1'b1;
                                    tdata_q  <= byte_d;
                                end else begin
                                    overrunErr_q <= 1'b1;
                                end
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hist_q <= '1;
        end else if (baud_clk) begin
            hist_q <= {hist_q[0], rxdSync_d};
        end
    end
`endif

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign busy          = (state_q != IDLE);
    assign frame_err     = frameErr_q;
    assign parity_err    = parityErr_q;
    assign overrun_err   = overrunErr_q;

endmodule
